// File: rtl/sram_bank_pkg.sv
// rtl/sram_bank_pkg.sv - shared types, default phase plan and slice helper for the sequenced SRAM bank
package sram_bank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_PHASES      = 10;
    localparam int DEF_ADDR_PHASE  = 2;
    localparam int DEF_READ_PHASE  = 6;
    localparam int DEF_WRITE_PHASE = 8;

    // LSB offset of port `port` inside a packed multi-port bus of `w`-bit slices
    function automatic int slice_lsb(input int port, input int w);
        return port * w;
    endfunction

endpackage

// File: rtl/bennett_phase_gen.sv
// rtl/bennett_phase_gen.sv - free-running phase counter emulating the Bennett square clock
module bennett_phase_gen
    import sram_bank_pkg::*;
#(
    parameter int PHASES = DEF_PHASES
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [$clog2(PHASES)-1:0]  phase,
    output logic                       instr_flag
);

    localparam int PW = $clog2(PHASES);
    localparam logic [PW-1:0] PH_LAST     = PW'(PHASES - 1);
    localparam logic [PW-1:0] PH_PRE_LAST = PW'(PHASES - 2);

    // instr_flag is registered so it is high exactly while phase == PHASES-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= '0;
            instr_flag <= 1'b0;
        end else begin
            phase      <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            instr_flag <= (phase == PH_PRE_LAST);
        end
    end

endmodule

// File: rtl/sram_nport_bank_seq.sv
// rtl/sram_nport_bank_seq.sv - phase-sequenced register-file bank, NRD read ports and one write port
module sram_nport_bank_seq
    import sram_bank_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int NRD         = 2,
    parameter int PHASES      = DEF_PHASES,
    parameter int ADDR_PHASE  = DEF_ADDR_PHASE,
    parameter int READ_PHASE  = DEF_READ_PHASE,
    parameter int WRITE_PHASE = DEF_WRITE_PHASE,
    parameter int RDW_MODE    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_waddr,
    input  logic [WIDTH-1:0]           req_wdata,
    input  logic [NRD*ADDR_W-1:0]      req_raddr,
    output logic                       rsp_valid,
    output logic [NRD*WIDTH-1:0]       rsp_rdata,
    output logic [$clog2(PHASES)-1:0]  phase,
    output logic                       instr_flag,
    output logic                       read_en,
    output logic                       write_en,
    output logic                       reg_wrt_bar
);

    localparam int PW = $clog2(PHASES);
    localparam logic [PW-1:0]     PH_ADDR     = PW'(ADDR_PHASE);
    localparam logic [PW-1:0]     PH_READ_M1  = PW'(READ_PHASE - 1);
    localparam logic [PW-1:0]     PH_WRITE_M1 = PW'(WRITE_PHASE - 1);
    localparam logic [PW-1:0]     PH_RSP_M1   = PW'(PHASES - 2);
    localparam logic [PW-1:0]     PH_LAST     = PW'(PHASES - 1);
    localparam logic [ADDR_W:0]   DEPTH_L     = (ADDR_W + 1)'(DEPTH);

    if (!(ADDR_PHASE >= 0 && ADDR_PHASE < READ_PHASE && READ_PHASE < WRITE_PHASE &&
          WRITE_PHASE < PHASES - 1) || NRD < 1) begin : g_cfg_err
        $error("sram_nport_bank_seq: illegal phase plan or port count");
    end

    state_t                  state, state_next;
    logic                    accept;
    logic                    read_en_d, write_en_d, rsp_valid_d;
    logic                    slot_we;
    logic [ADDR_W-1:0]       slot_waddr;
    logic [WIDTH-1:0]        slot_wdata;
    logic [NRD*ADDR_W-1:0]   slot_raddr;
    logic [NRD*WIDTH-1:0]    rd_word;
    logic [WIDTH-1:0]        mem [DEPTH];

    bennett_phase_gen #(.PHASES(PHASES)) u_phase (
        .clk        (clk),
        .reset      (reset),
        .phase      (phase),
        .instr_flag (instr_flag)
    );

    assign req_ready   = (phase == PH_ADDR);
    assign accept      = req_valid && req_ready;
    assign reg_wrt_bar = ~write_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Strobes are decoded one phase early so their registered copies line up with the target phase
    always_comb begin
        state_next  = state;
        read_en_d   = 1'b0;
        write_en_d  = 1'b0;
        rsp_valid_d = 1'b0;
        case (state)
            IDLE:    if (accept) state_next = ACTIVE;
            ACTIVE:  if (phase == PH_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state_next == ACTIVE) begin
            read_en_d   = (phase == PH_READ_M1);
            write_en_d  = slot_we && (phase == PH_WRITE_M1);
            rsp_valid_d = (phase == PH_RSP_M1);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              in_range;
        logic              bypass;
        assign ra       = slot_raddr[slice_lsb(i, ADDR_W) +: ADDR_W];
        assign in_range = ({1'b0, ra} < DEPTH_L);
        assign bypass   = (RDW_MODE != 0) && slot_we && (ra == slot_waddr);
        assign rd_word[slice_lsb(i, WIDTH) +: WIDTH] =
            !in_range ? '0 : (bypass ? slot_wdata : mem[ra]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_we    <= 1'b0;
            slot_waddr <= '0;
            slot_wdata <= '0;
            slot_raddr <= '0;
            read_en    <= 1'b0;
            write_en   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            read_en   <= read_en_d;
            write_en  <= write_en_d;
            rsp_valid <= rsp_valid_d;
            if (state == IDLE && accept) begin
                slot_we    <= req_we;
                slot_waddr <= req_waddr;
                slot_wdata <= req_wdata;
                slot_raddr <= req_raddr;
            end
            if (read_en) rsp_rdata <= rd_word;
        end
    end

    // The capture edge (READ_PHASE) precedes this one, so plain reads see the old word
    always_ff @(posedge clk) begin
        if (write_en && ({1'b0, slot_waddr} < DEPTH_L)) mem[slot_waddr] <= slot_wdata;
    end

endmodule

// File: tb/tb_sram_nport_bank_seq.sv
// tb/tb_sram_nport_bank_seq.sv - randomized self-checking bench for sram_nport_bank_seq
module tb_sram_nport_bank_seq;

    localparam int PHASES = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [4:0]  req_waddr = '0;
    logic [15:0] req_wdata = '0;
    logic [4:0]  ra0 = '0, ra1 = '0, ra2 = '0, ra3 = '0;
    logic [9:0]  raddr0;
    logic [19:0] raddr1;

    logic        ready0, rv0, flag0, ren0, wen0, wbar0;
    logic [31:0] rdata0;
    logic [3:0]  phase0;
    logic        ready1, rv1, flag1, ren1, wen1, wbar1;
    logic [63:0] rdata1;
    logic [3:0]  phase1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit active = 1'b0;
    bit act_we = 1'b0;

    logic [15:0] m0 [32];
    logic [15:0] m1 [24];

    always #5 clk = ~clk;

    assign raddr0 = {ra1, ra0};
    assign raddr1 = {ra3, ra2, ra1, ra0};

    sram_nport_bank_seq #(.WIDTH(16), .DEPTH(32), .NRD(2), .RDW_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
        .req_we(req_we), .req_waddr(req_waddr), .req_wdata(req_wdata), .req_raddr(raddr0),
        .rsp_valid(rv0), .rsp_rdata(rdata0), .phase(phase0), .instr_flag(flag0),
        .read_en(ren0), .write_en(wen0), .reg_wrt_bar(wbar0)
    );

    sram_nport_bank_seq #(.WIDTH(16), .DEPTH(24), .NRD(4), .RDW_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_waddr(req_waddr), .req_wdata(req_wdata), .req_raddr(raddr1),
        .rsp_valid(rv1), .rsp_rdata(rdata1), .phase(phase1), .instr_flag(flag1),
        .read_en(ren1), .write_en(wen1), .reg_wrt_bar(wbar1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Clocks since reset release; the phase is simply this count modulo PHASES
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int cur_ph();
        return cyc % PHASES;
    endfunction

    // Expected {read_en, write_en, ~reg_wrt_bar, rsp_valid} for the current clock
    function automatic logic [3:0] exp_strobes();
        int ph = cyc % PHASES;
        return {active && ph == 6, active && act_we && ph == 8,
                active && act_we && ph == 8, active && ph == PHASES - 1};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("phase", {phase1, phase0}, {4'(cur_ph()), 4'(cur_ph())});
            check("req_ready", {ready1, ready0}, {2{reset && cur_ph() == 2}});
            check("instr_flag", {flag1, flag0}, {2{reset && cur_ph() == PHASES - 1}});
            check("strobes0", {ren0, wen0, ~wbar0, rv0}, exp_strobes());
            check("strobes1", {ren1, wen1, ~wbar1, rv1}, exp_strobes());
        end
    end

    function automatic logic [15:0] rd0(input logic [4:0] a);
        return m0[a];
    endfunction

    function automatic logic [15:0] rd1(input logic [4:0] a, input bit we,
                                        input logic [4:0] wa, input logic [15:0] wd);
        if (a >= 5'd24) return '0;
        if (we && a == wa) return wd;
        return m1[a];
    endfunction

    task automatic transact(input bit we, input logic [4:0] wa, input logic [15:0] wd,
                            input logic [4:0] a0, input logic [4:0] a1,
                            input logic [4:0] a2, input logic [4:0] a3,
                            input bit chk, input int abort_ph, output int waited);
        logic [31:0] e0;
        logic [63:0] e1;
        e0 = {rd0(a1), rd0(a0)};
        e1 = {rd1(a3, we, wa, wd), rd1(a2, we, wa, wd), rd1(a1, we, wa, wd), rd1(a0, we, wa, wd)};
        req_we = we; req_waddr = wa; req_wdata = wd;
        ra0 = a0; ra1 = a1; ra2 = a2; ra3 = a3;
        req_valid = 1'b1;
        waited = 0;
        while (ready0 !== 1'b1 && waited < 3 * PHASES) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", waited < 3 * PHASES, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        active = 1'b1;
        act_we = we;
        req_we = 1'($urandom); req_waddr = 5'($urandom); req_wdata = 16'($urandom);
        ra0 = 5'($urandom); ra1 = 5'($urandom); ra2 = 5'($urandom); ra3 = 5'($urandom);
        if (abort_ph >= 0) begin
            repeat (abort_ph - 3) @(posedge clk);
            #1;
            reset = 1'b0;
            active = 1'b0;
            #1;
            check("abort_rdata0", rdata0, 32'h0);
            check("abort_rdata1", rdata1, 64'h0);
            check("abort_outputs", {ren0, wen0, wbar0, rv0, ren1, wen1, wbar1, rv1}, 8'b0010_0010);
            check("abort_phase", {phase1, phase0}, 8'h00);
            @(posedge clk);
            #1;
            reset = 1'b1;
            check("release_phase", {phase1, phase0}, 8'h00);
            return;
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check("rdata0", rdata0, e0);
            check("rdata1", rdata1, e1);
        end
        @(posedge clk);
        #1;
        active = 1'b0;
        if (we) begin
            m0[wa] = wd;
            if (wa < 5'd24) m1[wa] = wd;
        end
    endtask

    initial begin
        int w;
        int guard;
        bit rwe;
        logic [4:0] rwa;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata0", rdata0, 32'h0);
        check("reset_rdata1", rdata1, 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int a = 0; a < 32; a++)
            transact(1'b1, 5'(a), 16'(a * 257), 5'(a), 5'(a), 5'(a), 5'(a), 1'b0, -1, w);

        // write then read the top address on every port
        transact(1'b1, 5'd31, 16'hAAAA, 5'd0, 5'd1, 5'd2, 5'd4, 1'b1, -1, w);
        transact(1'b0, 5'd0, 16'h0, 5'd31, 5'd31, 5'd31, 5'd31, 1'b1, -1, w);

        // independent ports
        transact(1'b1, 5'd3, 16'h1234, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, w);
        transact(1'b1, 5'd5, 16'hBEEF, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, w);
        transact(1'b1, 5'd10, 16'h0A0A, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, w);
        transact(1'b1, 5'd12, 16'h0C0C, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, w);
        transact(1'b0, 5'd0, 16'h0, 5'd3, 5'd5, 5'd10, 5'd12, 1'b1, -1, w);

        // read-during-write: old word on dut0, bypassed new word on dut1
        transact(1'b1, 5'd7, 16'h0001, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, w);
        transact(1'b1, 5'd7, 16'h00FF, 5'd7, 5'd7, 5'd7, 5'd3, 1'b1, -1, w);
        transact(1'b0, 5'd0, 16'h0, 5'd7, 5'd7, 5'd7, 5'd7, 1'b1, -1, w);

        // request raised at phase 4 waits for the next phase 2
        guard = 0;
        while (cur_ph() != 4 && guard < 3 * PHASES) begin
            @(negedge clk);
            guard++;
        end
        check("reach_phase4", cur_ph(), 4);
        transact(1'b0, 5'd0, 16'h0, 5'd5, 5'd3, 5'd12, 5'd10, 1'b1, -1, w);
        check("handshake_wait", w, 8);
        repeat (2 * PHASES) @(negedge clk);

        // reset during a pending write
        transact(1'b1, 5'd9, 16'h0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, w);
        transact(1'b1, 5'd9, 16'h5555, 5'd9, 5'd9, 5'd9, 5'd9, 1'b0, 7, w);
        transact(1'b0, 5'd0, 16'h0, 5'd9, 5'd9, 5'd9, 5'd9, 1'b1, -1, w);

        // out-of-range handling on the 24-word bank
        transact(1'b1, 5'd23, 16'h1717, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, w);
        transact(1'b1, 5'd30, 16'hFFFF, 5'd30, 5'd23, 5'd30, 5'd23, 1'b1, -1, w);
        transact(1'b0, 5'd0, 16'h0, 5'd30, 5'd23, 5'd30, 5'd23, 1'b1, -1, w);

        for (int n = 0; n < 80; n++) begin
            rwe = 1'($urandom);
            rwa = 5'($urandom);
            transact(rwe, rwa, 16'($urandom),
                     ($urandom % 3 == 0) ? rwa : 5'($urandom), 5'($urandom),
                     ($urandom % 3 == 0) ? rwa : 5'($urandom), 5'($urandom),
                     1'b1, -1, w);
            if ($urandom % 5 == 0) repeat (PHASES) @(negedge clk);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
